fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 212 +++++++++++++++++++++
 tb/tb_fetch_unit.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch sequencer. It requests one instruction at pc_counter,
// waits for the memory acknowledge, and presents the instruction to decode.
// It then waits for decode to supply the next-PC fields, computes the next PC,
// and starts the next fetch. An acknowledge timeout or a misaligned next PC
// puts the block into a FAULT state. That state is left only by reset.
//
// Optional feature macro: FETCH_PERF_CNT_EN
//   When defined, fetch_count and stall_count are live performance counters.
//   When undefined, both outputs are tied to 0 and no counter flops exist.
//
// Ports
//   clk                 rising-edge clock
//   rst                 asynchronous, active-low reset
//   imem_req            instruction-memory read request (registered)
//   imem_addr           read address, always equal to pc_counter
//   imem_ack/imem_rdata read-data valid strobe and data
//   instruction_data    instruction presented to decode
//   instruction_RDY_BSY 1 = instruction valid, 0 = busy
//   decoder_rdy_bsy     1 = decode accepts in this cycle
//   next_pc_valid       one-cycle strobe qualifying pc_offset/pc_jump_address/
//                       pc_absolute_flag
//   pc_counter          address of the current instruction
//   fetch_fault         sticky fault flag
//   fetch_count         completed transfers (perf counter)
//   stall_count         WAIT/PRESENT cycles without a transfer (perf counter)
//   state_dbg           current FSM state encoding, for observation only
//
// Handshake: an instruction moves to decode on every rising edge where
// instruction_RDY_BSY=1 and decoder_rdy_bsy=1. The instruction is held stable
// until that edge. Memory returns data on a rising edge where imem_req=1 and
// imem_ack=1. imem_ack is ignored at all other times.
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [7:0]  IMEM_TIMEOUT = 8'd64
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction_data,
  output logic        instruction_RDY_BSY,
  input  logic        decoder_rdy_bsy,
  input  logic        next_pc_valid,
  input  logic [12:0] pc_offset,
  input  logic [31:0] pc_jump_address,
  input  logic        pc_absolute_flag,
  output logic [31:0] pc_counter,
  output logic        fetch_fault,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count,
  output logic [2:0]  state_dbg
);

  typedef enum logic [2:0] {
    S_REQ     = 3'd0,
    S_WAIT    = 3'd1,
    S_PRESENT = 3'd2,
    S_WAIT_PC = 3'd3,
    S_FAULT   = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        req_q, req_d;
  logic [31:0] data_q, data_d;
  logic        rdy_q, rdy_d;
  logic        fault_q, fault_d;
  logic [7:0]  tmo_q, tmo_d;
  logic [7:0]  tmo_inc;
  logic [31:0] next_pc;

  // Candidate next PC. It is only used while in WAIT_PC on a strobe.
  // Relative targets wrap modulo 2^32.
  always_comb begin
    tmo_inc = tmo_q + 8'd1;
    if (pc_absolute_flag) begin
      next_pc = {pc_jump_address[31:1], 1'b0};
    end else begin
      next_pc = pc_q + {{19{pc_offset[12]}}, pc_offset};
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    req_d   = req_q;
    data_d  = data_q;
    rdy_d   = rdy_q;
    fault_d = fault_q;
    tmo_d   = tmo_q;
    case (state_q)
      S_REQ: begin
        req_d   = 1'b1;
        tmo_d   = 8'd0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        req_d = 1'b1;
        if (imem_ack) begin
          data_d  = imem_rdata;
          req_d   = 1'b0;
          rdy_d   = 1'b1;
          state_d = S_PRESENT;
        end else if (tmo_inc == IMEM_TIMEOUT) begin
          // IMEM_TIMEOUT WAIT cycles have passed without an acknowledge.
          req_d   = 1'b0;
          fault_d = 1'b1;
          state_d = S_FAULT;
        end else begin
          tmo_d = tmo_inc;
        end
      end
      S_PRESENT: begin
        rdy_d = 1'b1;
        if (decoder_rdy_bsy) begin
          rdy_d   = 1'b0;
          state_d = S_WAIT_PC;
        end
      end
      S_WAIT_PC: begin
        // The strobe is only sampled once this state is registered. A strobe
        // in the accepting PRESENT cycle is therefore dropped.
        if (next_pc_valid) begin
          if (next_pc[1:0] != 2'b00) begin
            fault_d = 1'b1;
            state_d = S_FAULT;
          end else begin
            pc_d    = next_pc;
            state_d = S_REQ;
          end
        end
      end
      S_FAULT: begin
        req_d   = 1'b0;
        rdy_d   = 1'b0;
        fault_d = 1'b1;
      end
      default: begin
        req_d   = 1'b0;
        rdy_d   = 1'b0;
        fault_d = 1'b1;
        state_d = S_FAULT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_REQ;
      pc_q    <= RESET_PC;
      req_q   <= 1'b0;
      data_q  <= 32'd0;
      rdy_q   <= 1'b0;
      fault_q <= 1'b0;
      tmo_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= req_d;
      data_q  <= data_d;
      rdy_q   <= rdy_d;
      fault_q <= fault_d;
      tmo_q   <= tmo_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic        transfer;
  logic        stall;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    transfer    = (state_q == S_PRESENT) && decoder_rdy_bsy;
    stall       = (state_q == S_WAIT) ||
                  ((state_q == S_PRESENT) && !decoder_rdy_bsy);
    fetch_cnt_d = transfer ? fetch_cnt_q + 32'd1 : fetch_cnt_q;
    stall_cnt_d = stall ? stall_cnt_q + 32'd1 : stall_cnt_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt_q <= 32'd0;
      stall_cnt_q <= 32'd0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fetch_count = fetch_cnt_q;
  assign stall_count = stall_cnt_q;
`else
  assign fetch_count = 32'd0;
  assign stall_count = 32'd0;
`endif

  assign imem_req            = req_q;
  assign imem_addr           = pc_q;
  assign pc_counter          = pc_q;
  assign instruction_data    = data_q;
  assign instruction_RDY_BSY = rdy_q;
  assign fetch_fault         = fault_q;
  assign state_dbg           = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC     = 32'h0000_0000;
  localparam logic [7:0]  IMEM_TIMEOUT = 8'd64;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instruction_data;
  logic        instruction_RDY_BSY;
  logic        decoder_rdy_bsy;
  logic        next_pc_valid;
  logic [12:0] pc_offset;
  logic [31:0] pc_jump_address;
  logic        pc_absolute_flag;
  logic [31:0] pc_counter;
  logic        fetch_fault;
  logic [31:0] fetch_count;
  logic [31:0] stall_count;
  logic [2:0]  state_dbg;

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  fetch_unit #(.RESET_PC(RESET_PC), .IMEM_TIMEOUT(IMEM_TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instruction_data(instruction_data),
    .instruction_RDY_BSY(instruction_RDY_BSY),
    .decoder_rdy_bsy(decoder_rdy_bsy),
    .next_pc_valid(next_pc_valid), .pc_offset(pc_offset),
    .pc_jump_address(pc_jump_address), .pc_absolute_flag(pc_absolute_flag),
    .pc_counter(pc_counter), .fetch_fault(fetch_fault),
    .fetch_count(fetch_count), .stall_count(stall_count),
    .state_dbg(state_dbg)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete fetch: memory response after ack_dly extra WAIT cycles,
  // decode stalls dec_dly cycles. With noise set, strobes arrive outside
  // WAIT_PC and an acknowledge arrives outside WAIT. All of them must be
  // ignored.
  task automatic do_fetch(input logic [31:0] exp_addr, input logic [31:0] rdata,
                          input int ack_dly, input int dec_dly, input bit noise,
                          input string name);
    int n;
    logic [31:0] exp, fc0, sc0;
    n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (imem_req !== 1'b1) begin
      errors++;
      $display("FAIL %s_req: imem_req=%b, expected 1 within 20 cycles", name, imem_req);
      return;
    end
    checks++;
    if (imem_addr !== exp_addr) begin
      errors++;
      $display("FAIL %s_addr: imem_addr=%h expected %h", name, imem_addr, exp_addr);
    end
    if (noise) begin
      next_pc_valid = 1'b1; pc_absolute_flag = 1'b1; pc_jump_address = 32'h0000_0300;
      tick();
      next_pc_valid = 1'b0; pc_absolute_flag = 1'b0;
    end
    repeat (ack_dly) tick();
    checks++;
    if (instruction_RDY_BSY !== 1'b0) begin
      errors++;
      $display("FAIL %s_busy: instruction_RDY_BSY=%b expected 0 before ack", name, instruction_RDY_BSY);
    end
    imem_ack = 1'b1; imem_rdata = rdata;
    exp_q.push_back(rdata);
    tick();
    imem_ack = 1'b0; imem_rdata = $urandom;
    fc0 = fetch_count; sc0 = stall_count;
    checks++;
    if (instruction_RDY_BSY !== 1'b1 || imem_req !== 1'b0) begin
      errors++;
      $display("FAIL %s_present: rdy=%b req=%b expected rdy=1 req=0", name, instruction_RDY_BSY, imem_req);
    end
    for (int i = 0; i < dec_dly; i++) begin
      tick();
      checks++;
      if (instruction_RDY_BSY !== 1'b1 || instruction_data !== exp_q[0]) begin
        errors++;
        $display("FAIL %s_stall%0d: rdy=%b data=%h expected rdy=1 data=%h", name, i,
                 instruction_RDY_BSY, instruction_data, exp_q[0]);
      end
    end
    decoder_rdy_bsy = 1'b1;
    if (noise) begin
      next_pc_valid = 1'b1; pc_absolute_flag = 1'b1; pc_jump_address = 32'h0000_0300;
    end
    exp = exp_q.pop_front();
    checks++;
    if (instruction_data !== exp) begin
      errors++;
      $display("FAIL %s_data: instruction_data=%h expected %h", name, instruction_data, exp);
    end
    tick();
    decoder_rdy_bsy = 1'b0; next_pc_valid = 1'b0; pc_absolute_flag = 1'b0;
    checks++;
    if (instruction_RDY_BSY !== 1'b0) begin
      errors++;
      $display("FAIL %s_rdy_drop: instruction_RDY_BSY=%b expected 0", name, instruction_RDY_BSY);
    end
`ifdef FETCH_PERF_CNT_EN
    checks++;
    if (fetch_count - fc0 !== 32'd1 || stall_count - sc0 !== 32'(dec_dly)) begin
      errors++;
      $display("FAIL %s_perf: fetch delta=%0d stall delta=%0d expected 1 and %0d", name,
               fetch_count - fc0, stall_count - sc0, dec_dly);
    end
`else
    checks++;
    if (fetch_count !== 32'd0 || stall_count !== 32'd0 || fc0 !== 32'd0 || sc0 !== 32'd0) begin
      errors++;
      $display("FAIL %s_perf_off: fetch_count=%h stall_count=%h expected 0", name, fetch_count, stall_count);
    end
`endif
    if (noise) begin
      imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      tick();
      imem_ack = 1'b0;
      tick();
      checks++;
      if (imem_req !== 1'b0 || instruction_data !== exp || fetch_fault !== 1'b0) begin
        errors++;
        $display("FAIL %s_ignore: req=%b data=%h fault=%b expected req=0 data=%h fault=0", name,
                 imem_req, instruction_data, fetch_fault, exp);
      end
    end
  endtask

  task automatic send_next(input logic abs_f, input logic [12:0] off, input logic [31:0] jump);
    next_pc_valid = 1'b1; pc_absolute_flag = abs_f; pc_offset = off; pc_jump_address = jump;
    tick();
    next_pc_valid = 1'b0; pc_absolute_flag = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b0; imem_ack = 1'b0; imem_rdata = 32'd0; decoder_rdy_bsy = 1'b0;
    next_pc_valid = 1'b0; pc_offset = 13'd0; pc_jump_address = 32'd0; pc_absolute_flag = 1'b0;
    repeat (3) tick();
    checks++;
    if (imem_req !== 1'b0 || pc_counter !== RESET_PC || imem_addr !== RESET_PC ||
        instruction_data !== 32'd0 || instruction_RDY_BSY !== 1'b0 || fetch_fault !== 1'b0 ||
        fetch_count !== 32'd0 || stall_count !== 32'd0) begin
      errors++;
      $display("FAIL reset_values: req=%b pc=%h data=%h rdy=%b fault=%b fc=%h sc=%h expected all 0",
               imem_req, pc_counter, instruction_data, instruction_RDY_BSY, fetch_fault,
               fetch_count, stall_count);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (imem_req !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: imem_req=%b expected 0 before first edge", imem_req);
    end
    @(posedge clk); #1;
    checks++;
    if (imem_req !== 1'b1) begin
      errors++;
      $display("FAIL first_req: imem_req=%b expected 1 after first edge", imem_req);
    end
  endtask

  task automatic test_first_fetch();
    do_fetch(32'h0000_0000, 32'h0050_0093, 1, 0, 1'b0, "first");
  endtask

  task automatic test_relative();
    send_next(1'b0, 13'h0010, 32'd0);
    do_fetch(32'h0000_0010, $urandom, 0, 0, 1'b0, "rel_fwd");
    send_next(1'b0, 13'h1FF8, 32'd0);
    do_fetch(32'h0000_0008, $urandom, 2, 1, 1'b0, "rel_back");
  endtask

  task automatic test_absolute();
    send_next(1'b1, 13'h1FFC, 32'h0000_0101);
    do_fetch(32'h0000_0100, $urandom, 0, 0, 1'b0, "abs");
  endtask

  task automatic test_ignored();
    send_next(1'b0, 13'h0004, 32'd0);
    do_fetch(32'h0000_0104, 32'h1234_5678, 1, 0, 1'b1, "noise");
    send_next(1'b0, 13'h0004, 32'd0);
    do_fetch(32'h0000_0108, $urandom, 0, 0, 1'b0, "after_noise");
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    a = 32'h0000_0108;
    for (int i = 0; i < 4; i++) begin
      a = a + 32'd4;
      send_next(1'b0, 13'h0004, 32'd0);
      do_fetch(a, $urandom, $urandom_range(0, 3), $urandom_range(0, 2), 1'b0, "b2b");
    end
  endtask

  task automatic test_reset_mid_wait();
    send_next(1'b1, 13'd0, 32'h0000_0400);
    tick(); tick(); tick();
    #2;
    rst = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hBAD0_0BAD;
    #1;
    checks++;
    if (pc_counter !== RESET_PC || imem_req !== 1'b0 || instruction_RDY_BSY !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_wait: pc=%h req=%b rdy=%b expected pc=%h req=0 rdy=0",
               pc_counter, imem_req, instruction_RDY_BSY, RESET_PC);
    end
    tick();
    rst = 1'b1;
    tick();
    imem_ack = 1'b0;
    do_fetch(RESET_PC, 32'h0A0B_0C0D, 0, 0, 1'b0, "resume");
  endtask

  task automatic test_stall();
    send_next(1'b0, 13'h0020, 32'd0);
    do_fetch(32'h0000_0020, 32'hCAFE_F00D, 1, 5, 1'b0, "stall5");
  endtask

  task automatic test_wrap();
    send_next(1'b0, 13'h1FDC, 32'd0);
    do_fetch(32'hFFFF_FFFC, $urandom, 0, 0, 1'b0, "wrap_low");
    send_next(1'b0, 13'h0004, 32'd0);
    do_fetch(32'h0000_0000, $urandom, 0, 0, 1'b0, "wrap_zero");
  endtask

  task automatic test_misaligned();
    int reqs;
    send_next(1'b0, 13'h0002, 32'd0);
    reqs = 0;
    for (int i = 0; i < 10; i++) begin
      if (imem_req === 1'b1) reqs++;
      tick();
    end
    checks++;
    if (fetch_fault !== 1'b1 || reqs !== 0 || instruction_RDY_BSY !== 1'b0) begin
      errors++;
      $display("FAIL misaligned: fault=%b req_cycles=%0d rdy=%b expected fault=1 req_cycles=0 rdy=0",
               fetch_fault, reqs, instruction_RDY_BSY);
    end
  endtask

  task automatic test_timeout();
    int n;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    n = 0;
    while (imem_req === 1'b1 && n < 200) begin
      n++;
      tick();
    end
    checks++;
    if (n !== int'(IMEM_TIMEOUT) || fetch_fault !== 1'b1) begin
      errors++;
      $display("FAIL timeout: req_cycles=%0d fault=%b expected %0d and 1", n, fetch_fault, IMEM_TIMEOUT);
    end
    repeat (3) tick();
    checks++;
    if (imem_req !== 1'b0 || fetch_fault !== 1'b1) begin
      errors++;
      $display("FAIL fault_sticky: req=%b fault=%b expected req=0 fault=1", imem_req, fetch_fault);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (fetch_fault !== 1'b0 || pc_counter !== RESET_PC) begin
      errors++;
      $display("FAIL fault_clear: fault=%b pc=%h expected 0 and %h", fetch_fault, pc_counter, RESET_PC);
    end
    rst = 1'b1;
    do_fetch(RESET_PC, $urandom, 1, 0, 1'b0, "post_fault");
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_first_fetch();
    test_relative();
    test_absolute();
    test_ignored();
    test_back_to_back();
    test_reset_mid_wait();
    test_stall();
    test_wrap();
    test_misaligned();
    test_timeout();
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
